regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
// - Parametrised general-purpose register file for the pipelined CPU: NUM_RD combinational read ports, one write port.
// - Optional write-to-read bypass. Optional hard-wired zero register.
// - Per-register pending-write scoreboard: decode issues, writeback retires, hazard logic reads busy bits.
// - Registered write-trace port, consumed by the bench logger.
// PARAMETERS
// - DATA_W    32  width of each register
// - ADDR_W    5   register address width; depth = 2**ADDR_W
// - NUM_RD    2   number of read ports (1..4)
// - BYPASS    1   1: a write in the current cycle is visible on matching read ports; 0: visible from the next cycle
// - ZERO_REG  1   1: register 0 always reads 0, is never written and is never tracked
// - PEND_MAX  3   maximum outstanding issued writes per register (1..7)
// PORTS
// - clk          in   1              rising-edge clock
// - reset        in   1              reset, synchronous, active-high
// - rd_addr      in   NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
// - rd_data      out  NUM_RD*DATA_W  read data, packed the same way
// - rd_busy      out  NUM_RD         register has an outstanding write that has not been resolved
// - we           in   1              write enable
// - wa           in   ADDR_W         write address
// - wd           in   DATA_W         write data
// - wpc          in   32             PC of the writing instruction, for trace only
// - iss_en       in   1              issue request: an instruction with destination iss_addr enters the pipe
// - iss_addr     in   ADDR_W         destination register of the issue
// - iss_ready    out  1              issue can be accepted this cycle
// - tr_valid     out  1              one-cycle pulse: an effective write happened on the previous edge
// - tr_pc        out  32             trace PC
// - tr_addr      out  ADDR_W         trace address
// - tr_data      out  DATA_W         trace data
// - err_underflow out 1              sticky flag: a write retired a register whose count was 0
// BEHAVIOUR
// - All state changes on posedge clk. reset=1 has priority over every other input.
// - On reset: all registers = 0, all pending counters = 0, tr_* = 0, err_underflow = 0.
// - Resulting outputs after reset: rd_data = 0, rd_busy = 0, iss_ready = 1.
// - Effective write: eff_we = we && !(ZERO_REG && wa == 0). Register wa takes wd at the edge.
// - Read port i (combinational):
//   - ZERO_REG && addr == 0 -> 0
//   - else BYPASS && eff_we && wa == addr -> wd
//   - else mem[addr]
// - Scoreboard: one counter per register, width clog2(PEND_MAX+1).
//   - Issue accepted: acc = iss_en && iss_ready. Accepted issue increments cnt[iss_addr].
//   - Every eff_we decrements cnt[wa] if nonzero.
//   - If cnt[wa] == 0: data is still written, the counter stays 0, err_underflow sets.
// - Same register, same cycle, accepted issue and eff_we: counter unchanged (net zero).
//   - Exception: if cnt == 0, the counter becomes 1 and err_underflow sets.
// - iss_ready = 1 when ZERO_REG && iss_addr == 0 (r0 is never counted).
//   - Otherwise iss_ready = (cnt[iss_addr] != PEND_MAX) || (eff_we && wa == iss_addr).
//   - The decrement in that cycle frees the slot.
// - Issue to r0 with ZERO_REG=1: accepted, no state change.
// - rd_busy[i] = cnt[addr] != 0, except:
//   - forced 0 when BYPASS && eff_we && wa == addr && cnt[addr] == 1 (value is being delivered now);
//   - forced 0 for r0 when ZERO_REG.
// - Trace: on each eff_we, tr_valid=1 and tr_pc/tr_addr/tr_data = wpc/wa/wd at the next cycle.
//   - Otherwise tr_valid=0 and tr_pc/tr_addr/tr_data hold their values.
//   - Latency is exactly 1 cycle. No backpressure.
// - Reset mid-operation: in-flight issues are discarded, counters = 0, any write in that cycle is dropped, no trace pulse.
// TESTING
// - Reset: write 0xDEADBEEF to r5, assert reset 1 cycle -> r5 reads 0, rd_busy=0, iss_ready=1, tr_valid=0, err_underflow=0.
// - Bypass: we=1, wa=7, wd=0x1234, rd_addr0=7 in the same cycle -> rd_data0=0x1234 with BYPASS=1; with BYPASS=0 the old value, then 0x1234 next cycle; tr_valid=1 next cycle, tr_addr=7.
// - Zero reg: write 0xFFFFFFFF to r0 -> reads 0, no tr_valid pulse, iss_en to r0 leaves iss_ready=1 and rd_busy=0.
// - Saturation (PEND_MAX=3): 3 issues to r9 -> iss_ready=0, rd_busy=1; 4th issue plus write to r9 in the same cycle -> accepted, count stays 3; 3 more writes -> rd_busy=0.
// - Underflow: write r4 with count 0 -> data written, err_underflow=1 and stays 1 until reset.
// - Reset mid-op: 2 issues to r3, then reset together with a write to r3 -> r3=0, count=0, no trace pulse.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Port bundle for the register file: read ports, write port, issue handshake and write trace.
// The master side is the pipeline (decode/writeback); the slave side is the register file.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     we;
    logic [ADDR_W-1:0]        wa;
    logic [DATA_W-1:0]        wd;
    logic [31:0]              wpc;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     iss_ready;
    logic                     tr_valid;
    logic [31:0]              tr_pc;
    logic [ADDR_W-1:0]        tr_addr;
    logic [DATA_W-1:0]        tr_data;
    logic                     err_underflow;

    modport master (
        output rd_addr, we, wa, wd, wpc, iss_en, iss_addr,
        input  rd_data, rd_busy, iss_ready, tr_valid, tr_pc, tr_addr, tr_data, err_underflow
    );

    modport slave (
        input  rd_addr, we, wa, wd, wpc, iss_en, iss_addr,
        output rd_data, rd_busy, iss_ready, tr_valid, tr_pc, tr_addr, tr_data, err_underflow
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// General-purpose register file with combinational read ports, optional write bypass,
// optional hard-wired zero register, per-register pending-write scoreboard and write trace.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1,
    parameter int PEND_MAX = 3
) (
    input  logic                clk,
    input  logic                reset,
    regfile_scoreboard_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = $clog2(PEND_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PEND_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [CNT_W-1:0]  cnt     [DEPTH];
    logic [CNT_W-1:0]  cnt_nxt [DEPTH];

    logic              eff_we;
    logic              iss_zero;
    logic              iss_ready_c;
    logic              acc_cnt;
    logic              underflow;
    logic [DEPTH-1:0]  inc_v;
    logic [DEPTH-1:0]  dec_v;

    logic                           tr_valid_q;
    logic [31:0]                    tr_pc_q;
    logic [ADDR_W-1:0]              tr_addr_q;
    logic [DATA_W-1:0]              tr_data_q;
    logic                           err_q;
    logic [NUM_RD-1:0][DATA_W-1:0]  rd_data_c;
    logic [NUM_RD-1:0]              rd_busy_c;

    // Write and issue qualification; r0 is invisible to the scoreboard when hard-wired.
    always_comb begin
        // NOTE: every combinational output is given a value before any branch, so no latch is inferred.
        eff_we      = 1'b0;
        iss_zero    = 1'b0;
        iss_ready_c = 1'b1;
        acc_cnt     = 1'b0;
        underflow   = 1'b0;

        eff_we   = bus.we && !(ZERO_REG && bus.wa == '0);
        iss_zero = ZERO_REG && bus.iss_addr == '0;
        if (!iss_zero) begin
            // A write to the same register this cycle frees the slot it is asking for.
            iss_ready_c = (cnt[bus.iss_addr] != CNT_MAX) || (eff_we && bus.wa == bus.iss_addr);
        end
        acc_cnt   = bus.iss_en && iss_ready_c && !iss_zero;
        underflow = eff_we && cnt[bus.wa] == '0;
    end

    assign bus.iss_ready = iss_ready_c;

    // Per-register counter update: issue increments, effective write decrements, both cancel.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int r = 0; r < DEPTH; r++) begin
            inc_v[r]   = acc_cnt && bus.iss_addr == ADDR_W'(r);
            dec_v[r]   = eff_we && bus.wa == ADDR_W'(r);
            cnt_nxt[r] = cnt[r];
            if (inc_v[r] && dec_v[r]) begin
                // Retiring a write nobody issued still leaves the new issue outstanding.
                if (cnt[r] == '0) begin
                    cnt_nxt[r] = CNT_ONE;
                end
            end else if (inc_v[r]) begin
                cnt_nxt[r] = cnt[r] + CNT_ONE;
            end else if (dec_v[r] && cnt[r] != '0) begin
                cnt_nxt[r] = cnt[r] - CNT_ONE;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit_zero;
        logic              hit_wr;

        assign addr     = bus.rd_addr[i*ADDR_W +: ADDR_W];
        assign hit_zero = ZERO_REG && addr == '0;
        assign hit_wr   = BYPASS && eff_we && bus.wa == addr;

        assign rd_data_c[i] = hit_zero ? '0 : (hit_wr ? bus.wd : mem[addr]);
        // The last outstanding write being bypassed right now means the value is already available.
        assign rd_busy_c[i] = !hit_zero && cnt[addr] != '0 && !(hit_wr && cnt[addr] == CNT_ONE);
    end

    assign bus.rd_data = rd_data_c;
    assign bus.rd_busy = rd_busy_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the register array is flop-based and cleared on reset; software relies on all-zero registers.
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
                cnt[r] <= '0;
            end
            tr_valid_q <= 1'b0;
            tr_pc_q    <= '0;
            tr_addr_q  <= '0;
            tr_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            for (int r = 0; r < DEPTH; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            if (eff_we) begin
                mem[bus.wa] <= bus.wd;
                tr_pc_q     <= bus.wpc;
                tr_addr_q   <= bus.wa;
                tr_data_q   <= bus.wd;
            end
            tr_valid_q <= eff_we;
            if (underflow) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.tr_valid      = tr_valid_q;
    assign bus.tr_pc         = tr_pc_q;
    assign bus.tr_addr       = tr_addr_q;
    assign bus.tr_data       = tr_data_q;
    assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one DUT with write bypass, one without.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();
    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_nb ();

    regfile_scoreboard #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1'b1), .ZERO_REG(1'b1), .PEND_MAX(3)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    regfile_scoreboard #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1'b0), .ZERO_REG(1'b1), .PEND_MAX(3)
    ) dut_nb (
        .clk(clk), .reset(reset), .bus(bus_nb.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.we = 1'b0;    bus.wa = '0;    bus.wd = '0;    bus.wpc = '0;
        bus.iss_en = 1'b0;    bus.iss_addr = '0;    bus.rd_addr = '0;
        bus_nb.we = 1'b0; bus_nb.wa = '0; bus_nb.wd = '0; bus_nb.wpc = '0;
        bus_nb.iss_en = 1'b0; bus_nb.iss_addr = '0; bus_nb.rd_addr = '0;
    endtask

    task automatic do_reset;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'hDEADBEEF; bus.wpc = 32'h40;
        tick();
        idle();
        bus.rd_addr = {5'd0, 5'd5};
        bus.iss_addr = 5'd5;
        #1;
        n_cmp++; if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL pre_reset_r5 got=%h exp=%h", bus.rd_data[31:0], 32'hDEADBEEF); end
        n_cmp++; if (bus.err_underflow !== 1'b1) begin n_bad++; $display("FAIL pre_reset_err got=%b exp=1", bus.err_underflow); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.rd_data[31:0] !== 32'h0) begin n_bad++; $display("FAIL reset_r5 got=%h exp=0", bus.rd_data[31:0]); end
        n_cmp++; if (bus.rd_busy !== 2'b00) begin n_bad++; $display("FAIL reset_busy got=%b exp=00", bus.rd_busy); end
        n_cmp++; if (bus.iss_ready !== 1'b1) begin n_bad++; $display("FAIL reset_iss_ready got=%b exp=1", bus.iss_ready); end
        n_cmp++; if (bus.tr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tr_valid got=%b exp=0", bus.tr_valid); end
        n_cmp++; if (bus.err_underflow !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", bus.err_underflow); end
        n_cmp++; if ({bus.tr_pc, bus.tr_data} !== 64'h0) begin n_bad++; $display("FAIL reset_trace got=%h/%h exp=0/0", bus.tr_pc, bus.tr_data); end
    endtask

    task automatic test_bypass;
        do_reset();
        bus.iss_en = 1'b1;    bus.iss_addr = 5'd7;
        bus_nb.iss_en = 1'b1; bus_nb.iss_addr = 5'd7;
        tick();
        idle();
        bus.we = 1'b1;    bus.wa = 5'd7;    bus.wd = 32'h1234;    bus.wpc = 32'h100;    bus.rd_addr = {5'd7, 5'd7};
        bus_nb.we = 1'b1; bus_nb.wa = 5'd7; bus_nb.wd = 32'h1234; bus_nb.wpc = 32'h100; bus_nb.rd_addr = {5'd7, 5'd7};
        #1;
        n_cmp++; if (bus.rd_data !== {32'h1234, 32'h1234}) begin n_bad++; $display("FAIL byp_rd got=%h exp=%h", bus.rd_data, {32'h1234, 32'h1234}); end
        n_cmp++; if (bus.rd_busy !== 2'b00) begin n_bad++; $display("FAIL byp_busy got=%b exp=00", bus.rd_busy); end
        n_cmp++; if (bus_nb.rd_data[31:0] !== 32'h0) begin n_bad++; $display("FAIL nobyp_rd_old got=%h exp=0", bus_nb.rd_data[31:0]); end
        n_cmp++; if (bus_nb.rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL nobyp_busy got=%b exp=1", bus_nb.rd_busy[0]); end
        tick();
        idle();
        bus.rd_addr = {5'd7, 5'd7};
        bus_nb.rd_addr = {5'd7, 5'd7};
        #1;
        n_cmp++; if (bus.tr_valid !== 1'b1) begin n_bad++; $display("FAIL byp_tr_valid got=%b exp=1", bus.tr_valid); end
        n_cmp++; if (bus.tr_addr !== 5'd7) begin n_bad++; $display("FAIL byp_tr_addr got=%0d exp=7", bus.tr_addr); end
        n_cmp++; if (bus.tr_data !== 32'h1234) begin n_bad++; $display("FAIL byp_tr_data got=%h exp=1234", bus.tr_data); end
        n_cmp++; if (bus.tr_pc !== 32'h100) begin n_bad++; $display("FAIL byp_tr_pc got=%h exp=100", bus.tr_pc); end
        n_cmp++; if (bus.err_underflow !== 1'b0) begin n_bad++; $display("FAIL byp_err got=%b exp=0", bus.err_underflow); end
        n_cmp++; if (bus_nb.rd_data[31:0] !== 32'h1234) begin n_bad++; $display("FAIL nobyp_rd_new got=%h exp=1234", bus_nb.rd_data[31:0]); end
        n_cmp++; if (bus_nb.rd_busy[0] !== 1'b0) begin n_bad++; $display("FAIL nobyp_busy_after got=%b exp=0", bus_nb.rd_busy[0]); end
        n_cmp++; if (bus_nb.tr_valid !== 1'b1 || bus_nb.tr_addr !== 5'd7) begin n_bad++; $display("FAIL nobyp_trace got=%b/%0d exp=1/7", bus_nb.tr_valid, bus_nb.tr_addr); end
        tick();
        n_cmp++; if (bus.tr_valid !== 1'b0) begin n_bad++; $display("FAIL byp_tr_pulse got=%b exp=0", bus.tr_valid); end
        n_cmp++; if (bus.tr_data !== 32'h1234) begin n_bad++; $display("FAIL byp_tr_hold got=%h exp=1234", bus.tr_data); end
    endtask

    task automatic test_zero_reg;
        do_reset();
        bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hFFFFFFFF; bus.wpc = 32'h200;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd0; bus.rd_addr = {5'd0, 5'd0};
        #1;
        n_cmp++; if (bus.rd_data[31:0] !== 32'h0) begin n_bad++; $display("FAIL zero_rd_same got=%h exp=0", bus.rd_data[31:0]); end
        n_cmp++; if (bus.iss_ready !== 1'b1) begin n_bad++; $display("FAIL zero_iss_ready got=%b exp=1", bus.iss_ready); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.tr_valid !== 1'b0) begin n_bad++; $display("FAIL zero_tr_valid got=%b exp=0", bus.tr_valid); end
        n_cmp++; if (bus.rd_data[31:0] !== 32'h0) begin n_bad++; $display("FAIL zero_rd_after got=%h exp=0", bus.rd_data[31:0]); end
        n_cmp++; if (bus.rd_busy !== 2'b00) begin n_bad++; $display("FAIL zero_busy got=%b exp=00", bus.rd_busy); end
        n_cmp++; if (bus.err_underflow !== 1'b0) begin n_bad++; $display("FAIL zero_err got=%b exp=0", bus.err_underflow); end
    endtask

    task automatic test_saturation;
        do_reset();
        bus.rd_addr = {5'd0, 5'd9};
        for (int k = 0; k < 3; k++) begin
            bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
            #1;
            n_cmp++; if (bus.iss_ready !== 1'b1) begin n_bad++; $display("FAIL sat_ready_%0d got=%b exp=1", k, bus.iss_ready); end
            tick();
        end
        #1;
        n_cmp++; if (bus.iss_ready !== 1'b0) begin n_bad++; $display("FAIL sat_full got=%b exp=0", bus.iss_ready); end
        n_cmp++; if (bus.rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL sat_busy got=%b exp=1", bus.rd_busy[0]); end
        bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h99;
        #1;
        n_cmp++; if (bus.iss_ready !== 1'b1) begin n_bad++; $display("FAIL sat_free_slot got=%b exp=1", bus.iss_ready); end
        n_cmp++; if (bus.rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL sat_busy_wr got=%b exp=1", bus.rd_busy[0]); end
        tick();
        idle();
        bus.rd_addr = {5'd0, 5'd9}; bus.iss_addr = 5'd9;
        #1;
        n_cmp++; if (bus.iss_ready !== 1'b0) begin n_bad++; $display("FAIL sat_net_zero got=%b exp=0", bus.iss_ready); end
        n_cmp++; if (bus.rd_data[31:0] !== 32'h99) begin n_bad++; $display("FAIL sat_data got=%h exp=99", bus.rd_data[31:0]); end
        for (int k = 0; k < 3; k++) begin
            bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h90 + 32'(k);
            tick();
            bus.we = 1'b0;
            #1;
            n_cmp++; if (bus.rd_busy[0] !== (k < 2)) begin n_bad++; $display("FAIL sat_drain_%0d got=%b exp=%b", k, bus.rd_busy[0], k < 2); end
            n_cmp++; if (bus.iss_ready !== 1'b1) begin n_bad++; $display("FAIL sat_drain_ready_%0d got=%b exp=1", k, bus.iss_ready); end
        end
        n_cmp++; if (bus.rd_data[31:0] !== 32'h92) begin n_bad++; $display("FAIL sat_last_data got=%h exp=92", bus.rd_data[31:0]); end
        n_cmp++; if (bus.err_underflow !== 1'b0) begin n_bad++; $display("FAIL sat_err got=%b exp=0", bus.err_underflow); end
    endtask

    task automatic test_underflow;
        bus.we = 1'b1; bus.wa = 5'd4; bus.wd = 32'h4444; bus.rd_addr = {5'd0, 5'd4};
        tick();
        bus.we = 1'b0;
        #1;
        n_cmp++; if (bus.rd_data[31:0] !== 32'h4444) begin n_bad++; $display("FAIL uf_data got=%h exp=4444", bus.rd_data[31:0]); end
        n_cmp++; if (bus.err_underflow !== 1'b1) begin n_bad++; $display("FAIL uf_set got=%b exp=1", bus.err_underflow); end
        bus.iss_en = 1'b1; bus.iss_addr = 5'd6; bus.we = 1'b1; bus.wa = 5'd6; bus.wd = 32'h6666;
        tick();
        idle();
        bus.rd_addr = {5'd0, 5'd6};
        #1;
        n_cmp++; if (bus.rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL uf_issue_same got=%b exp=1", bus.rd_busy[0]); end
        n_cmp++; if (bus.rd_data[31:0] !== 32'h6666) begin n_bad++; $display("FAIL uf_issue_data got=%h exp=6666", bus.rd_data[31:0]); end
        tick(); tick(); tick();
        n_cmp++; if (bus.err_underflow !== 1'b1) begin n_bad++; $display("FAIL uf_sticky got=%b exp=1", bus.err_underflow); end
        do_reset();
        bus.rd_addr = {5'd0, 5'd6};
        #1;
        n_cmp++; if (bus.err_underflow !== 1'b0) begin n_bad++; $display("FAIL uf_cleared got=%b exp=0", bus.err_underflow); end
        n_cmp++; if (bus.rd_busy[0] !== 1'b0) begin n_bad++; $display("FAIL uf_cnt_cleared got=%b exp=0", bus.rd_busy[0]); end
    endtask

    task automatic test_reset_midop;
        do_reset();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd3; bus.rd_addr = {5'd0, 5'd3};
        tick();
        tick();
        bus.iss_en = 1'b0;
        #1;
        n_cmp++; if (bus.rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL mid_busy got=%b exp=1", bus.rd_busy[0]); end
        reset = 1'b1;
        bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'h3333; bus.wpc = 32'h500;
        tick();
        reset = 1'b0;
        bus.we = 1'b0;
        #1;
        n_cmp++; if (bus.rd_data[31:0] !== 32'h0) begin n_bad++; $display("FAIL mid_r3 got=%h exp=0", bus.rd_data[31:0]); end
        n_cmp++; if (bus.rd_busy[0] !== 1'b0) begin n_bad++; $display("FAIL mid_cnt got=%b exp=0", bus.rd_busy[0]); end
        n_cmp++; if (bus.tr_valid !== 1'b0) begin n_bad++; $display("FAIL mid_tr_valid got=%b exp=0", bus.tr_valid); end
        n_cmp++; if (bus.tr_data !== 32'h0) begin n_bad++; $display("FAIL mid_tr_data got=%h exp=0", bus.tr_data); end
        n_cmp++; if (bus.iss_ready !== 1'b1) begin n_bad++; $display("FAIL mid_iss_ready got=%b exp=1", bus.iss_ready); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bus.we = 1'b1; bus.wa = 5'(10 + k); bus.wd = 32'hA0 + 32'(k); bus.wpc = 32'h300 + 32'(4 * k);
            tick();
            n_cmp++; if (bus.tr_valid !== 1'b1 || bus.tr_addr !== 5'(10 + k)) begin n_bad++; $display("FAIL b2b_tr_%0d got=%b/%0d exp=1/%0d", k, bus.tr_valid, bus.tr_addr, 10 + k); end
            n_cmp++; if (bus.tr_data !== 32'hA0 + 32'(k) || bus.tr_pc !== 32'h300 + 32'(4 * k)) begin n_bad++; $display("FAIL b2b_trd_%0d got=%h/%h exp=%h/%h", k, bus.tr_data, bus.tr_pc, 32'hA0 + 32'(k), 32'h300 + 32'(4 * k)); end
        end
        idle();
        bus.rd_addr = {5'd10, 5'd12};
        tick();
        n_cmp++; if (bus.tr_valid !== 1'b0 || bus.tr_addr !== 5'd12) begin n_bad++; $display("FAIL b2b_hold got=%b/%0d exp=0/12", bus.tr_valid, bus.tr_addr); end
        n_cmp++; if (bus.rd_data !== {32'hA0, 32'hA2}) begin n_bad++; $display("FAIL b2b_ports got=%h exp=%h", bus.rd_data, {32'hA0, 32'hA2}); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_saturation();
        test_underflow();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench did not finish in time");
    end
endmodule
